regfile_mp_scb: RTL and testbench
=================================

// Module: regfile_mp_scb
// PURPOSE
//  Parametrised multi-read-port general register file for the pipelined CPU.
//  - Byte-enabled writes and same-cycle write-to-read bypass.
//  - Per-entry scoreboard (busy) bits so decode can detect RAW hazards.
//  - Post-reset clear sequencer: every entry reads 0 once init_done is high.
//  Sits between decode (reads, busy_set) and writeback (writes, busy clear).
// PARAMETERS
//  DATA_W   32  register width in bits; must be a multiple of 8
//  ADDR_W   5   address width; DEPTH = 2**ADDR_W entries
//  NREAD    2   number of independent read ports
//  ZERO_REG 1   1: entry 0 hardwired to zero, never busy; 0: entry 0 is ordinary
// PORTS
//  clk         in   1              rising-edge clock
//  resetn      in   1              asynchronous active-low reset
//  init_done   out  1              1 once the clear sequence has finished
//  wen         in   DATA_W/8       write byte enables; any bit set = write
//  waddr       in   ADDR_W         write address
//  wdata       in   DATA_W         write data
//  raddr       in   NREAD*ADDR_W   read addresses; port i = bits [i*ADDR_W +: ADDR_W]
//  rdata       out  NREAD*DATA_W   read data; port i = bits [i*DATA_W +: DATA_W]
//  rbusy       out  NREAD          scoreboard bit of raddr[i], after bypass/clear
//  busy_set    in   1              mark busy_addr busy (instruction issued)
//  busy_addr   in   ADDR_W         destination register being issued
// BEHAVIOUR
//  Reset (resetn=0, async):
//   - state=INIT, clear counter=0, init_done=0, all busy bits=0.
//   - Array contents are not reset directly; the sequencer clears them.
//  INIT state:
//   - Each clk writes 0 to entry cnt, then cnt++.
//   - After entry DEPTH-1 is written, state=RUN and init_done=1 (registered).
//   - init_done rises exactly DEPTH cycles after resetn deasserts.
//   - wen and busy_set are ignored; rdata=0 and rbusy=0 on all ports.
//  RUN state:
//   - Write, on the clk edge: for each byte b with wen[b]=1, entry[waddr] byte b
//     <= wdata byte b. Other bytes are unchanged.
//   - Read, combinational, per port i:
//     - If ZERO_REG and raddr=0: rdata=0.
//     - Else if wen!=0 and waddr=raddr: bypass. Enabled bytes come from wdata;
//       the remaining bytes come from the stored entry.
//     - Else: rdata=entry[raddr].
//   - Scoreboard, on the clk edge:
//     - Any write with wen!=0 clears busy[waddr].
//     - busy_set=1 sets busy[busy_addr].
//     - Set and clear on the same address in the same cycle: set wins (new producer).
//     - ZERO_REG: writes and busy_set to entry 0 are dropped; busy[0] stays 0.
//   - rbusy[i]=busy[raddr[i]], except 0 when a same-cycle write clears that entry
//     (consistent with the bypass). A same-cycle busy_set is not visible until
//     the next cycle.
//   - NREAD ports are fully independent; identical addresses give identical results.
//  resetn asserted mid-operation:
//   - Returns to INIT immediately; the clear sequence restarts from 0.
//   - In-flight writes are discarded.
// STRUCTURE
//  Package regfile_pkg:
//   - State enum {RF_INIT, RF_RUN}.
//   - Function rf_merge_bytes(old, new, be) shared by the write path and the bypass.
//  Sub-module regfile_init_seq:
//   - ADDR_W-bit counter, state register, init_done.
//   - Outputs clr_we and clr_addr.
//  Top level: write-port mux (clear vs. external), storage array, NREAD-way
//  generate loop of read/bypass logic, busy vector.
// TESTING
//  1. Release resetn; hold wen=4'hF, waddr=3 during INIT -> init_done rises at
//     cycle 32; entry 3 reads 0 (write ignored).
//  2. RUN: write 32'hDEADBEEF to r5 (wen=F), then wen=4'b0010, wdata=32'h0000_5500
//     -> r5 reads 32'hDEAD55EF.
//  3. Same-cycle write 32'h12345678 to r7 while raddr0=7 -> rdata0=32'h12345678
//     in that cycle (bypass).
//  4. busy_set r9, then one idle cycle -> rbusy=1. Next cycle: write r9 and
//     busy_set r9 together -> busy[r9] stays 1.
//  5. ZERO_REG=1: write 32'hFFFFFFFF and busy_set to r0 -> rdata=0, rbusy=0.
//     Repeat with ZERO_REG=0 -> r0 holds 32'hFFFFFFFF.
//  6. Pulse resetn low mid-run with busy bits set -> busy=0, init_done=0, and after
//     32 cycles every entry reads 0 on all NREAD=4 ports.

Source files
------------

// File: rtl/regfile_mp_scb_pkg.sv
// Shared types for the multi-port register file: sequencer states and the
// byte-merge helper used by both the write path and the read bypass.
package regfile_pkg;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

    // Widest register supported by the merge helper; callers cast in and out.
    localparam int RF_MAX_W  = 128;
    localparam int RF_MAX_BE = RF_MAX_W / 8;

    typedef logic [RF_MAX_W-1:0]  rf_wide_t;
    typedef logic [RF_MAX_BE-1:0] rf_be_t;

    function automatic rf_wide_t rf_merge_bytes(input rf_wide_t old_v,
                                                input rf_wide_t new_v,
                                                input rf_be_t   be);
        rf_wide_t r;
        r = old_v;
        for (int b = 0; b < RF_MAX_BE; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_mp_scb_if.sv
// Decode/writeback bus of the register file: write port, read ports,
// scoreboard set port and the init_done status.
interface regfile_mp_scb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic [DATA_W/8-1:0]     wen;
    logic [ADDR_W-1:0]       waddr;
    logic [DATA_W-1:0]       wdata;
    logic [NREAD*ADDR_W-1:0] raddr;
    logic [NREAD*DATA_W-1:0] rdata;
    logic [NREAD-1:0]        rbusy;
    logic                    busy_set;
    logic [ADDR_W-1:0]       busy_addr;
    logic                    init_done;

    modport master (
        output wen, waddr, wdata, raddr, busy_set, busy_addr,
        input  rdata, rbusy, init_done
    );

    modport slave (
        input  wen, waddr, wdata, raddr, busy_set, busy_addr,
        output rdata, rbusy, init_done
    );
endinterface

// File: rtl/regfile_mp_scb_init_seq.sv
// Post-reset clear sequencer: sweeps every entry once, then enables normal use.
//  state   | meaning
//  RF_INIT | writing 0 to entry cnt_q each cycle, external port blocked
//  RF_RUN  | clear finished, init_done high, external port live
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              init_done_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);
    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_o = 1'b0;
        case (state_q)
            RF_INIT: begin
                clr_we_o = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = RF_RUN;
            end
            default: ;
        endcase
    end

    assign clr_addr_o  = cnt_q;
    assign init_done_o = (state_q == RF_RUN);
endmodule

// File: rtl/regfile_mp_scb.sv
// Multi-read-port register file with byte-enabled writes, write-to-read
// bypass, per-entry busy scoreboard and a post-reset clear sequence.
module regfile_mp_scb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            resetn,
    regfile_mp_scb_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    typedef logic [DATA_W-1:0] word_t;

    logic              run;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_any;
    logic              ext_we;
    word_t             mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    regfile_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
        .clk         (clk),
        .resetn      (resetn),
        .init_done_o (run),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr)
    );

    assign rf.init_done = run;
    assign wr_any       = run && (|rf.wen);
    assign ext_we       = wr_any && !(ZR && rf.waddr == '0);

    // Storage is never reset; the sequencer owns the port until the sweep is done.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (ext_we) begin
            mem_q[rf.waddr] <= word_t'(rf_merge_bytes(rf_wide_t'(mem_q[rf.waddr]),
                                                      rf_wide_t'(rf.wdata),
                                                      rf_be_t'(rf.wen)));
        end
    end

    // A same-cycle set beats the clear: the new issue is the newer producer.
    always_comb begin
        busy_d = busy_q;
        if (run) begin
            if (wr_any)      busy_d[rf.waddr]     = 1'b0;
            if (rf.busy_set) busy_d[rf.busy_addr] = 1'b1;
        end
        if (ZR) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;
        word_t             rd;
        logic              rb;

        assign ra  = rf.raddr[i*ADDR_W +: ADDR_W];
        assign hit = wr_any && (rf.waddr == ra);

        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (run && !(ZR && ra == '0)) begin
                if (hit) begin
                    rd = word_t'(rf_merge_bytes(rf_wide_t'(mem_q[ra]),
                                                rf_wide_t'(rf.wdata),
                                                rf_be_t'(rf.wen)));
                end else begin
                    rd = mem_q[ra];
                    rb = busy_q[ra];
                end
            end
        end

        assign rf.rdata[i*DATA_W +: DATA_W] = rd;
        assign rf.rbusy[i]                  = rb;
    end
endmodule

// File: tb/tb_regfile_mp_scb.sv
// Scoreboard bench: two 4-read-port instances (zero register on / off) share
// one randomized stimulus stream and are checked against an array-based model.
module tb_regfile_mp_scb;
    import regfile_pkg::*;

    typedef struct {
        logic [127:0] rd [2];
        logic [3:0]   rb [2];
        logic         id;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic [3:0]  wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [19:0] raddr;
    logic        busy_set;
    logic [4:0]  busy_addr;

    int tests = 0;
    int fails = 0;
    exp_t q [$];

    bit [31:0] m_mem  [2][32];
    bit        m_busy [2][32];
    int        init_left;

    regfile_mp_scb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(4)) if_z ();
    regfile_mp_scb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(4)) if_n ();

    regfile_mp_scb #(.DATA_W(32), .ADDR_W(5), .NREAD(4), .ZERO_REG(1)) dut_z (
        .clk(clk), .resetn(resetn), .rf(if_z));
    regfile_mp_scb #(.DATA_W(32), .ADDR_W(5), .NREAD(4), .ZERO_REG(0)) dut_n (
        .clk(clk), .resetn(resetn), .rf(if_n));

    assign if_z.wen = wen;           assign if_n.wen = wen;
    assign if_z.waddr = waddr;       assign if_n.waddr = waddr;
    assign if_z.wdata = wdata;       assign if_n.wdata = wdata;
    assign if_z.raddr = raddr;       assign if_n.raddr = raddr;
    assign if_z.busy_set = busy_set; assign if_n.busy_set = busy_set;
    assign if_z.busy_addr = busy_addr; assign if_n.busy_addr = busy_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] be);
        bit [31:0] r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic void model_reset();
        init_left = 32;
        for (int k = 0; k < 2; k++) for (int a = 0; a < 32; a++) m_busy[k][a] = 1'b0;
    endfunction

    // Expected combinational view of instance k for the inputs now applied.
    function automatic void model_out(input int k, output logic [127:0] rd, output logic [3:0] rb);
        rd = '0;
        rb = '0;
        for (int p = 0; p < 4; p++) begin
            int ra = int'(raddr[p*5 +: 5]);
            if (init_left > 0 || (k == 0 && ra == 0)) continue;
            if (wen != 4'h0 && int'(waddr) == ra) begin
                rd[p*32 +: 32] = merge(m_mem[k][ra], wdata, wen);
            end else begin
                rd[p*32 +: 32] = m_mem[k][ra];
                rb[p]          = m_busy[k][ra];
            end
        end
    endfunction

    function automatic void model_edge();
        if (!resetn) return;
        if (init_left > 0) begin
            init_left--;
            if (init_left == 0)
                for (int k = 0; k < 2; k++) for (int a = 0; a < 32; a++) m_mem[k][a] = '0;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (wen != 4'h0 && !(k == 0 && waddr == 5'd0)) begin
                m_mem[k][waddr]  = merge(m_mem[k][waddr], wdata, wen);
                m_busy[k][waddr] = 1'b0;
            end
            if (busy_set && !(k == 0 && busy_addr == 5'd0)) m_busy[k][busy_addr] = 1'b1;
        end
    endfunction

    task automatic cyc(input logic rn, input logic [3:0] we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] r3,
                       input logic bs, input logic [4:0] ba);
        exp_t it;
        @(posedge clk);
        #1;
        resetn = rn; wen = we; waddr = wa; wdata = wd;
        raddr = {r3, r2, r1, r0}; busy_set = bs; busy_addr = ba;
        if (!rn) model_reset();
        model_out(0, it.rd[0], it.rb[0]);
        model_out(1, it.rd[1], it.rb[1]);
        it.id = (init_left == 0);
        q.push_back(it);
        model_edge();
    endtask

    task automatic rnd_cyc(input logic rn);
        logic [3:0] we = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        cyc(rn, we, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            1'($urandom), 5'($urandom_range(0, 7)));
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t it;
            it = q.pop_front();
            tests++;
            if ({if_z.init_done, if_z.rbusy, if_z.rdata} !== {it.id, it.rb[0], it.rd[0]}) begin
                fails++;
                $display("FAIL sb_zero act=%b/%h/%h exp=%b/%h/%h", if_z.init_done, if_z.rbusy,
                         if_z.rdata, it.id, it.rb[0], it.rd[0]);
            end
            tests++;
            if ({if_n.init_done, if_n.rbusy, if_n.rdata} !== {it.id, it.rb[1], it.rd[1]}) begin
                fails++;
                $display("FAIL sb_plain act=%b/%h/%h exp=%b/%h/%h", if_n.init_done, if_n.rbusy,
                         if_n.rdata, it.id, it.rb[1], it.rd[1]);
            end
        end
    end

    initial begin
        resetn = 1'b0; wen = '0; waddr = '0; wdata = '0; raddr = '0;
        busy_set = 1'b0; busy_addr = '0;
        model_reset();

        cyc(0, 4'h0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0);
        cyc(0, 4'h0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            cyc(1, 4'hF, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3, 5'd3, 5'd3, 1, 5'd3);
            @(negedge clk);
            if (i == 31) chk("init_done_low_c31", 128'(if_z.init_done), 128'(0));
        end
        cyc(1, 4'h0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3, 5'd3, 0, 5'd0);
        @(negedge clk);
        chk("init_done_c32", 128'(if_z.init_done), 128'(1));
        chk("r3_after_init", 128'(if_n.rdata[31:0]), 128'(0));
        chk("r3_busy_after_init", 128'(if_n.rbusy), 128'(0));

        cyc(1, 4'hF, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5, 5'd5, 0, 5'd0);
        cyc(1, 4'b0010, 5'd5, 32'h0000_5500, 5'd5, 5'd5, 5'd5, 5'd5, 0, 5'd0);
        cyc(1, 4'h0, 5'd0, 32'h0, 5'd5, 5'd1, 5'd5, 5'd5, 0, 5'd0);
        @(negedge clk);
        chk("byte_merge_r5", 128'(if_z.rdata[31:0]), 128'(32'hDEAD55EF));

        cyc(1, 4'hF, 5'd7, 32'h12345678, 5'd7, 5'd0, 5'd0, 5'd7, 0, 5'd0);
        @(negedge clk);
        chk("bypass_r7", 128'(if_z.rdata[31:0]), 128'(32'h12345678));
        chk("bypass_r7_p3", 128'(if_n.rdata[127:96]), 128'(32'h12345678));

        cyc(1, 4'h0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9, 5'd9, 1, 5'd9);
        cyc(1, 4'h0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9, 5'd9, 0, 5'd0);
        @(negedge clk);
        chk("busy_r9", 128'(if_z.rbusy), 128'(4'hF));
        cyc(1, 4'hF, 5'd9, 32'h0BAD_F00D, 5'd9, 5'd9, 5'd9, 5'd9, 1, 5'd9);
        cyc(1, 4'h0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9, 5'd9, 0, 5'd0);
        @(negedge clk);
        chk("busy_set_wins", 128'(if_z.rbusy[0]), 128'(1));

        cyc(1, 4'hF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 5'd0, 1, 5'd0);
        cyc(1, 4'h0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0);
        @(negedge clk);
        chk("zero_reg_rdata", 128'(if_z.rdata[31:0]), 128'(0));
        chk("zero_reg_rbusy", 128'(if_z.rbusy), 128'(0));
        chk("plain_r0_rdata", 128'(if_n.rdata[31:0]), 128'(32'hFFFFFFFF));
        chk("plain_r0_rbusy", 128'(if_n.rbusy[0]), 128'(1));

        for (int i = 0; i < 400; i++) rnd_cyc(1);

        for (int a = 1; a < 8; a++)
            cyc(1, 4'h0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 5'(a));
        cyc(0, 4'hF, 5'd2, 32'h1, 5'd1, 5'd2, 5'd3, 5'd4, 1, 5'd2);
        @(negedge clk);
        chk("midrun_rst_init_done", 128'(if_n.init_done), 128'(0));
        chk("midrun_rst_rbusy", 128'(if_n.rbusy), 128'(0));
        for (int i = 0; i < 32; i++) rnd_cyc(1);
        for (int a = 0; a < 32; a++) begin
            cyc(1, 4'h0, 5'd0, 32'h0, 5'(a), 5'(a), 5'(a), 5'(a), 0, 5'd0);
            @(negedge clk);
            chk("reinit_zero_z", if_z.rdata, 128'(0));
            chk("reinit_zero_n", if_n.rdata, 128'(0));
        end

        for (int i = 0; i < 300; i++) rnd_cyc(1);
        @(negedge clk);
        @(posedge clk);
        chk("queue_drained", 128'(q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
